// File: rtl/quote_egress.sv
// Per-stock single-slot quote coalescer feeding a round-robin egress engine that
// streams each granted quote as buy and/or sell word packets over valid/ready.
module quote_egress #(
    parameter int NUM_STOCKS      = 4,
    parameter int REG_WIDTH       = 32,
    parameter int WORDS_PER_ORDER = 9,
    parameter int SIDE_MODE       = 0,
    localparam int SIDW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_quote_valid,
    input  logic [SIDW-1:0]                      i_stock_id,
    input  logic [WORDS_PER_ORDER*REG_WIDTH-1:0] i_buy_words,
    input  logic [WORDS_PER_ORDER*REG_WIDTH-1:0] i_sell_words,
    input  logic [NUM_STOCKS-1:0]                i_stock_enable,
    output logic [REG_WIDTH-1:0]                 o_word,
    output logic                                 o_word_valid,
    input  logic                                 i_word_ready,
    output logic                                 o_side,
    output logic [SIDW-1:0]                      o_stock_id,
    output logic                                 o_last,
    output logic [NUM_STOCKS-1:0]                o_pending,
    output logic [15:0]                          o_overwrite_count,
    output logic                                 o_busy
);
    localparam int CW = (WORDS_PER_ORDER > 1) ? $clog2(WORDS_PER_ORDER) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS_PER_ORDER - 1);

    typedef logic [WORDS_PER_ORDER-1:0][REG_WIDTH-1:0] packet_t;
    typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;

    state_t                state, state_next;
    packet_t               buy_slot  [NUM_STOCKS];
    packet_t               sell_slot [NUM_STOCKS];
    packet_t               frame_buy, frame_sell;
    logic [NUM_STOCKS-1:0] pending, wr, gmask;
    logic [SIDW-1:0]       last_grant, grant_id, frame_id, cand;
    logic                  grant, accept, side_end;
    logic [CW-1:0]         cnt;
    logic [15:0]           overwrite_count;

    // A quote only lands when its channel exists and is enabled; anything else is dropped.
    always_comb begin
        wr = '0;
        for (int i = 0; i < NUM_STOCKS; i++)
            wr[i] = i_quote_valid && i_stock_enable[i] && (i_stock_id == SIDW'(i));
    end

    // Round-robin search starting just after the channel granted last.
    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        cand     = '0;
        if (state == IDLE) begin
            for (int k = 1; k <= NUM_STOCKS; k++) begin
                cand = SIDW'((int'(last_grant) + k) % NUM_STOCKS);
                if (!grant && pending[cand]) begin
                    grant    = 1'b1;
                    grant_id = cand;
                end
            end
        end
    end

    always_comb begin
        gmask = '0;
        for (int i = 0; i < NUM_STOCKS; i++)
            gmask[i] = grant && (grant_id == SIDW'(i));
    end

    assign accept   = o_word_valid && i_word_ready;
    assign side_end = accept && (cnt == LAST_IDX);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = SEND_A;
            SEND_A:  if (side_end) state_next = (SIDE_MODE == 0) ? SEND_B : IDLE;
            SEND_B:  if (side_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_busy            = (state != IDLE);
    assign o_word_valid      = o_busy;
    assign o_side            = (state == SEND_B) || ((state == SEND_A) && (SIDE_MODE == 2));
    assign o_last            = o_busy && (cnt == LAST_IDX);
    assign o_word            = !o_busy ? '0 : (o_side ? frame_sell[cnt] : frame_buy[cnt]);
    assign o_stock_id        = frame_id;
    assign o_pending         = pending;
    assign o_overwrite_count = overwrite_count;

    // Control state: a new write to the slot being granted wins over the grant's clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pending         <= '0;
            overwrite_count <= '0;
            last_grant      <= SIDW'(NUM_STOCKS - 1);
            frame_id        <= '0;
            cnt             <= '0;
        end else begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                if (!i_stock_enable[i])
                    pending[i] <= 1'b0;
                else if (wr[i])
                    pending[i] <= 1'b1;
                else if (gmask[i])
                    pending[i] <= 1'b0;
            end
            if (|(wr & pending & ~gmask) && (overwrite_count != 16'hFFFF))
                overwrite_count <= overwrite_count + 16'd1;
            if (grant) begin
                last_grant <= grant_id;
                frame_id   <= grant_id;
                cnt        <= '0;
            end else if (accept) begin
                cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
            end
        end
    end

    // Slot and frame payloads carry no reset; o_word is gated to zero outside a packet.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_STOCKS; i++) begin
            if (wr[i]) begin
                buy_slot[i]  <= i_buy_words;
                sell_slot[i] <= i_sell_words;
            end
        end
        if (grant) begin
            frame_buy  <= buy_slot[grant_id];
            frame_sell <= sell_slot[grant_id];
        end
    end

endmodule

// File: tb/tb_quote_egress.sv
// Randomized scoreboard bench for quote_egress with a transaction-level reference model.
module tb_quote_egress;
    localparam int N   = 4;
    localparam int RW  = 32;
    localparam int WPO = 9;
    localparam int PW  = WPO * RW;

    typedef struct packed {
        logic [RW-1:0] word;
        logic          side;
        logic [1:0]    id;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          qv = 1'b0;
    logic [1:0]    qid = '0;
    logic [PW-1:0] buyw = '0, sellw = '0;
    logic [N-1:0]  en = '1, en2 = '0, en_nx = '1, en2_nx = '0;
    logic          rdy = 1'b1;

    logic [RW-1:0] word0, word2;
    logic          valid0, valid2, side0, side2, last0, last2, busy0, busy2;
    logic [1:0]    sid0, sid2;
    logic [N-1:0]  pend0, pend2;
    logic [15:0]   ovc0, ovc2;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t exp2_q[$];

    // Reference model: one slot per stock, outstanding-word count of the packet in flight.
    logic [RW-1:0] m_buy  [N][WPO];
    logic [RW-1:0] m_sell [N][WPO];
    logic [N-1:0]  m_pend;
    int            m_rem, m_last, m_cnt;

    quote_egress #(.NUM_STOCKS(N), .REG_WIDTH(RW), .WORDS_PER_ORDER(WPO), .SIDE_MODE(0)) dut (
        .i_clk(clk), .i_reset(rst), .i_quote_valid(qv), .i_stock_id(qid),
        .i_buy_words(buyw), .i_sell_words(sellw), .i_stock_enable(en),
        .o_word(word0), .o_word_valid(valid0), .i_word_ready(rdy), .o_side(side0),
        .o_stock_id(sid0), .o_last(last0), .o_pending(pend0),
        .o_overwrite_count(ovc0), .o_busy(busy0)
    );

    quote_egress #(.NUM_STOCKS(N), .REG_WIDTH(RW), .WORDS_PER_ORDER(WPO), .SIDE_MODE(2)) dut_sell (
        .i_clk(clk), .i_reset(rst), .i_quote_valid(qv), .i_stock_id(qid),
        .i_buy_words(buyw), .i_sell_words(sellw), .i_stock_enable(en2),
        .o_word(word2), .o_word_valid(valid2), .i_word_ready(rdy), .o_side(side2),
        .o_stock_id(sid2), .o_last(last2), .o_pending(pend2),
        .o_overwrite_count(ovc2), .o_busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [PW-1:0] pattern(input logic [RW-1:0] base);
        logic [PW-1:0] r;
        for (int w = 0; w < WPO; w++) r[w*RW +: RW] = base + RW'(w);
        return r;
    endfunction

    function automatic logic [PW-1:0] rand_words();
        logic [PW-1:0] r;
        for (int w = 0; w < WPO; w++) r[w*RW +: RW] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_pend = '0;
        m_rem  = 0;
        m_last = N - 1;
        m_cnt  = 0;
    endtask

    // Advance the model by one cycle using the inputs the DUT samples at the next edge.
    task automatic model_step();
        int         g;
        logic [1:0] c;
        exp_t       e;
        g = -1;
        if (m_rem > 0) begin
            if (rdy) m_rem--;
        end else if (m_pend != '0) begin
            for (int k = 1; k <= N; k++) begin
                c = 2'((m_last + k) % N);
                if (g < 0 && m_pend[c]) g = int'(c);
            end
            for (int s = 0; s < 2; s++) begin
                for (int w = 0; w < WPO; w++) begin
                    e.word = (s == 0) ? m_buy[g][w] : m_sell[g][w];
                    e.side = (s == 1);
                    e.id   = 2'(g);
                    e.last = (w == WPO - 1);
                    exp_q.push_back(e);
                end
            end
            m_rem  = 2 * WPO;
            m_last = g;
        end
        for (int i = 0; i < N; i++) begin
            if (!en[i]) begin
                m_pend[i] = 1'b0;
            end else if (qv && qid == 2'(i)) begin
                if (m_pend[i] && g != i && m_cnt < 65535) m_cnt++;
                for (int w = 0; w < WPO; w++) begin
                    m_buy[i][w]  = buyw[w*RW +: RW];
                    m_sell[i][w] = sellw[w*RW +: RW];
                end
                m_pend[i] = 1'b1;
            end else if (g == i) begin
                m_pend[i] = 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [1:0] id, input logic [PW-1:0] b,
                         input logic [PW-1:0] s, input logic r);
        @(posedge clk);
        #1;
        qv = v; qid = id; buyw = b; sellw = s; rdy = r; en = en_nx; en2 = en2_nx;
        @(negedge clk);
        check("pending", pend0, m_pend);
        check("overwrite_count", ovc0, m_cnt);
        check("busy", busy0, m_rem > 0);
        check("word_valid", valid0, m_rem > 0);
        model_step();
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && (m_rem > 0 || m_pend != '0); t++)
            cycle(1'b0, 2'd0, '0, '0, 1'b1);
        checks++;
        if (m_rem > 0 || m_pend != '0) begin
            errors++;
            $display("FAIL drain_timeout: remaining %0d pending 0x%0h, required idle", m_rem, m_pend);
        end
        #1;
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", valid0, 0);
        check("rst_word", word0, 0);
        check("rst_side", side0, 0);
        check("rst_stock_id", sid0, 0);
        check("rst_last", last0, 0);
        check("rst_pending", pend0, 0);
        check("rst_overwrite", ovc0, 0);
        check("rst_busy", busy0, 0);
        check("rst_valid_sell", valid2, 0);
    endtask

    // Monitor for the buy/sell instance, including hold-stability under backpressure.
    exp_t held;
    logic holding = 1'b0;
    always @(negedge clk) begin
        exp_t cur, e;
        cur = {word0, side0, sid0, last0};
        if (rst) begin
            holding = 1'b0;
        end else if (valid0) begin
            if (holding) check("hold_stable", cur, held);
            if (rdy) begin
                holding = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h, required no word", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("word", cur, e);
                end
            end else begin
                held    = cur;
                holding = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t cur, e;
        cur = {word2, side2, sid2, last2};
        if (!rst && valid2 && rdy) begin
            checks++;
            if (exp2_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sell_word: got 0x%0h, required no word", cur);
            end else begin
                e = exp2_q.pop_front();
                check("sell_only_word", cur, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Single quote, buy then sell packet.
        cycle(1'b1, 2'd2, pattern(32'h100), pattern(32'h200), 1'b1);
        drain();

        // All four stocks quoted back to back; served 0..3.
        for (int i = 0; i < N; i++)
            cycle(1'b1, 2'(i), pattern(32'h1000 * (i + 1)), pattern(32'h1800 * (i + 1)), 1'b1);
        drain();

        // Coalescing on stock 1 while stock 0 streams.
        cycle(1'b1, 2'd0, pattern(32'h2000), pattern(32'h2100), 1'b1);
        cycle(1'b1, 2'd1, pattern(32'h3000), pattern(32'h3100), 1'b1);
        cycle(1'b1, 2'd1, pattern(32'h4000), pattern(32'h4100), 1'b1);
        cycle(1'b1, 2'd1, pattern(32'h5000), pattern(32'h5100), 1'b1);
        drain();
        check("overwrite_total", ovc0, 2);

        // Backpressure held for five cycles on word 4.
        cycle(1'b1, 2'd2, pattern(32'h6000), pattern(32'h6100), 1'b1);
        for (int t = 0; t < 40 && m_rem != 2 * WPO - 4; t++) cycle(1'b0, 2'd0, '0, '0, 1'b1);
        repeat (5) cycle(1'b0, 2'd0, '0, '0, 1'b0);
        drain();

        // Reset during sell word 3 aborts the packet.
        cycle(1'b1, 2'd1, pattern(32'h7000), pattern(32'h7100), 1'b1);
        for (int t = 0; t < 40 && m_rem != WPO - 3; t++) cycle(1'b0, 2'd0, '0, '0, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) cycle(1'b0, 2'd0, '0, '0, 1'b1);
        drain();

        // Sell-only instance with stock 3 disabled.
        en_nx  = 4'b0111;
        en2_nx = 4'b0111;
        for (int w = 0; w < WPO; w++) begin
            e.word = 32'h400 + RW'(w);
            e.side = 1'b1;
            e.id   = 2'd0;
            e.last = (w == WPO - 1);
            exp2_q.push_back(e);
        end
        cycle(1'b1, 2'd3, pattern(32'h500), pattern(32'h600), 1'b1);
        cycle(1'b1, 2'd0, pattern(32'h300), pattern(32'h400), 1'b1);
        drain();
        check("sell_only_queue_empty", exp2_q.size(), 0);
        check("sell_only_pending", pend2, 0);
        check("sell_only_busy", busy2, 0);
        en_nx  = '1;
        en2_nx = '0;

        // Randomized traffic with random backpressure and enable toggling.
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 19) == 0)
                en_nx = 4'($urandom);
            else if ($urandom_range(0, 9) == 0)
                en_nx = '1;
            cycle($urandom_range(0, 9) < 3, 2'($urandom), rand_words(), rand_words(),
                  $urandom_range(0, 9) < 7);
        end
        en_nx = '1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quote_egress.md
QUOTE_EGRESS -- requirements
Module: quote_egress

Interface
REQ-001 Parameters (name, default, meaning), one per line: NUM_STOCKS, 4, stock channels; REG_WIDTH, 32, output word width; WORDS_PER_ORDER, 9, words per side packet; SIDE_MODE, 0, sides sent per quote (0=buy then sell, 1=buy only, 2=sell only). SIDW = max(1, clog2(NUM_STOCKS)).
REQ-002 Ports (name, direction, width, meaning), one per line:
i_clk  in  1  single clock; all state on rising edge.
i_reset  in  1  asynchronous active-high reset.
i_quote_valid  in  1  quote present this cycle.
i_stock_id  in  SIDW  channel of the quote.
i_buy_words  in  WORDS_PER_ORDER*REG_WIDTH  buy packet, word 0 in LSBs.
i_sell_words  in  WORDS_PER_ORDER*REG_WIDTH  sell packet, word 0 in LSBs.
i_stock_enable  in  NUM_STOCKS  per-channel enable.
o_word  out  REG_WIDTH  output word.
o_word_valid  out  1  o_word valid.
i_word_ready  in  1  downstream accepts word.
o_side  out  1  0=buy, 1=sell.
o_stock_id  out  SIDW  channel of current packet.
o_last  out  1  last word of current side packet.
o_pending  out  NUM_STOCKS  per-channel pending flags.
o_overwrite_count  out  16  saturating count of coalesced quotes.
o_busy  out  1  FSM not IDLE.

Function
REQ-003 Each channel SHALL hold one pending slot (buy words, sell words, pending flag); input is always accepted, no input backpressure.
REQ-004 Quote with i_quote_valid=1, i_stock_enable[i_stock_id]=1, i_stock_id<NUM_STOCKS SHALL write that slot and set pending on the next edge; otherwise the quote SHALL be dropped.
REQ-005 Write to an already-pending slot not granted in the same cycle SHALL overwrite it and increment o_overwrite_count, saturating at 16'hFFFF.
REQ-006 Clearing i_stock_enable[k] SHALL clear pending[k] next edge; a packet already in transmission SHALL complete.
REQ-007 FSM states: IDLE, SEND_A, SEND_B; o_busy=1 outside IDLE.
REQ-008 In IDLE with any pending, SHALL grant round-robin starting at (last granted+1) mod NUM_STOCKS, copy slot into frame register, clear its pending flag, go to SEND_A next edge.
REQ-009 Write to the granted channel in the grant cycle: frame SHALL take the old slot contents; new quote SHALL stay pending (set wins over clear); no overwrite count.
REQ-010 SEND_A SHALL send buy words (SIDE_MODE 0/1) or sell words (SIDE_MODE 2) 0..WORDS_PER_ORDER-1; SEND_B (SIDE_MODE 0 only) sends sell words.
REQ-011 Word counter SHALL advance only when o_word_valid & i_word_ready; o_word, o_side, o_stock_id, o_last SHALL stay stable while valid and not ready.
REQ-012 o_last=1 on word WORDS_PER_ORDER-1 of each side; on its acceptance SEND_A->SEND_B (SIDE_MODE 0) or ->IDLE; SEND_B->IDLE.
REQ-013 Latency: quote at edge N, idle FSM -> pending at N+1, grant during cycle N+1, first word valid cycle N+2; one IDLE bubble cycle between packets.
REQ-014 o_word_valid SHALL be 0 in IDLE; no word SHALL be emitted without a grant.
REQ-015 Out-of-range i_stock_id SHALL have no effect on any state.

Reset
REQ-016 i_reset=1 SHALL asynchronously force: FSM IDLE, o_word_valid=0, o_word=0, o_side=0, o_stock_id=0, o_last=0, o_pending=0, o_overwrite_count=0, o_busy=0, round-robin pointer so channel 0 is served first, word counter 0.
REQ-017 Reset mid-packet SHALL abort the packet; after release no residual words SHALL be emitted; slot data content need not be cleared.

Verification
REQ-018 Single quote stock 2, buy word k=0x100+k, sell word k=0x200+k, ready=1 -> 18 words from cycle N+2: 0x100..0x108 side 0 then 0x200..0x208 side 1, o_last on 0x108 and 0x208, o_stock_id=2.
REQ-019 Quotes for stocks 0..3 same cycle (staggered) with ready=1 -> packets in order 0,1,2,3, each preceded by one idle cycle; o_pending clears per grant.
REQ-020 Three quotes to stock 1 while stock 0 packet streams -> only third quote sent for stock 1; o_overwrite_count=2.
REQ-021 i_word_ready low 5 cycles on word 4 -> o_word and o_last held stable, no skipped or repeated word.
REQ-022 Assert i_reset during sell word 3 -> o_word_valid=0 immediately, all outputs at reset values; after release with no new quotes, no output.
REQ-023 SIDE_MODE=2, i_stock_enable[3]=0 -> quote to stock 3 dropped; quote to stock 0 emits 9 sell words only, o_side=1.
